// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared widths and FSM state type for the display datapath
//             (binary score values -> BCD digits -> seven-segment drivers).
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    localparam int BIN_W  = 15;   // binary value width (max 32767)
    localparam int BCD_W  = 20;   // five packed BCD digits
    localparam int DIGITS = 5;

    // Scheduler states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Index width for an n-wide requester vector, never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_share_sched_if
//  Purpose  : Request/result bundle between game-state logic, the shared
//             BCD converter and the BCD scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_share_sched_if
    import display_pkg::*;
#(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]       req;       // level request per requester
    logic [NREQ*BIN_W-1:0] value;     // binary value per requester
    logic [BIN_W-1:0]      conv_in;   // to shared converter
    logic [BCD_W-1:0]      conv_out;  // from shared converter
    logic [NREQ*BCD_W-1:0] bcd;       // registered result per requester
    logic [NREQ-1:0]       done;      // one-cycle update pulse per requester
    logic                  busy;      // scheduler not idle

    // Requesters plus converter side
    modport master (
        output req, value, conv_out,
        input  conv_in, bcd, done, busy
    );

    // Scheduler side
    modport slave (
        input  req, value, conv_out,
        output conv_in, bcd, done, busy
    );

endinterface : bcd_share_sched_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Grants the first set request
//             found searching upward from ptr, wrapping modulo NREQ.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    // Priority search starting at ptr; first hit wins
    always_comb begin
        int  pos;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bcd_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_share_sched
//  Purpose  : Time-shares one binary-to-BCD converter between NREQ requesters.
//             A granted value is held on conv_in for SETTLE cycles, then the
//             converter output is latched into that requester's bcd slot with
//             a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_share_sched
    import display_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int SETTLE = 64
) (
    input  logic              clk,
    input  logic              reset,
    bcd_share_sched_if.slave  bus
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = $clog2(SETTLE + 1);

    state_t                state_q,   state_d;
    logic [IDX_W-1:0]      gnt_q,     gnt_d;
    logic [IDX_W-1:0]      rr_q,      rr_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [BIN_W-1:0]      conv_in_q, conv_in_d;
    logic [NREQ*BCD_W-1:0] bcd_q,     bcd_d;
    logic [NREQ-1:0]       done_q,    done_d;

    logic [NREQ-1:0]       arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any = |arb_grant;

    // State, pointer, counter and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            conv_in_q <= '0;
            bcd_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            conv_in_q <= conv_in_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: arbitrate, load, settle, capture
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        conv_in_d = conv_in_q;   // converter input only moves in LOAD
        bcd_d     = bcd_q;
        done_d    = '0;          // done is a single-cycle pulse
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q == IDX_W'(i)) begin
                        conv_in_d = bus.value[i*BIN_W +: BIN_W];
                    end
                end
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q == IDX_W'(i)) begin
                        bcd_d[i*BCD_W +: BCD_W] = bus.conv_out;
                        done_d[i]               = 1'b1;
                    end
                end
                // Pointer moves past the served requester so others go first
                if (gnt_q == IDX_W'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = gnt_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.conv_in = conv_in_q;
    assign bus.bcd     = bcd_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);

endmodule : bcd_share_sched
`default_nettype wire

// File: tb/tb_bcd_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_share_sched
//  Purpose  : Self-checking bench for bcd_share_sched with a 31-cycle
//             sequential converter model on conv_in/conv_out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_share_sched;
    import display_pkg::*;

    localparam int NREQ   = 3;
    localparam int SETTLE = 64;
    localparam int LAT    = SETTLE + 3;
    localparam int CONV_P = 31;

    typedef struct {
        int          idx;
        logic [19:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    logic [19:0] model [NREQ];

    always #5 clk = ~clk;

    bcd_share_sched_if #(.NREQ(NREQ)) bus ();

    bcd_share_sched #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Converter model: samples its input once per period, result valid at period end
    function automatic logic [19:0] to_bcd(input logic [14:0] b);
        int v;
        v = int'(b);
        return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    int          ph = 0;
    logic [14:0] conv_lat = '0;
    logic [19:0] conv_q = '0;
    assign bus.conv_out = conv_q;

    always @(posedge clk) begin
        ph <= (ph == CONV_P - 1) ? 0 : ph + 1;
        if (ph == 0)          conv_lat <= bus.conv_in;
        if (ph == CONV_P - 1) conv_q   <= to_bcd(conv_lat);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expectation and checks all slots
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=%b expected none (cyc %0d)", bus.done, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_onehot", 32'(bus.done), 32'(1) << e.idx);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                model[e.idx] = e.val;
                for (int j = 0; j < NREQ; j++) begin
                    chk($sformatf("bcd%0d", j), 32'(bus.bcd[j*20 +: 20]), 32'(model[j]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_done(input int idx, input logic [19:0] val, input int c);
        sb_q.push_back('{idx: idx, val: val, cyc: c});
    endtask

    task automatic set_value(input int i, input int v);
        bus.value[i*15 +: 15] = 15'(v);
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done[i]) begin
            checks++;
            errors++;
            $display("FAIL timeout_done%0d: got no pulse expected pulse within %0d cycles", i, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int j = 0; j < NREQ; j++) model[j] = '0;
    endtask

    initial begin
        logic [14:0] snap;
        int c;
        reset     = 1'b1;
        bus.req   = '0;
        bus.value = '0;
        for (int j = 0; j < NREQ; j++) model[j] = '0;
        tick(3);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.bcd[59:32]), 32'd0);
        chk("rst_bcd_lo", bus.bcd[31:0], 32'd0);
        chk("rst_conv_in", 32'(bus.conv_in), 32'd0);
        reset = 1'b0;
        tick(1);

        // 1. single request
        set_value(0, 12345);
        bus.req = 3'b001;
        expect_done(0, 20'h12345, cyc + LAT);
        wait_done(0, 200);
        bus.req[0] = 1'b0;
        tick(3);

        // 2. all three requesting from a fresh pointer
        do_reset();
        set_value(0, 0);
        set_value(1, 32767);
        set_value(2, 9999);
        bus.req = 3'b111;
        c = cyc;
        expect_done(0, 20'h00000, c + LAT);
        expect_done(1, 20'h32767, c + 2*LAT);
        expect_done(2, 20'h09999, c + 3*LAT);
        wait_done(0, 200); bus.req[0] = 1'b0;
        wait_done(1, 200); bus.req[1] = 1'b0;
        wait_done(2, 200); bus.req[2] = 1'b0;
        tick(3);

        // 3. fairness: req0 held, req2 raised during the second service of 0
        set_value(0, 5);
        bus.req[0] = 1'b1;
        c = cyc;
        expect_done(0, 20'h00005, c + LAT);
        expect_done(0, 20'h00005, c + 2*LAT);
        expect_done(2, 20'h00777, c + 3*LAT);
        expect_done(0, 20'h00005, c + 4*LAT);
        tick(100);
        set_value(2, 777);
        bus.req[2] = 1'b1;
        wait_done(2, 300); bus.req[2] = 1'b0;
        wait_done(0, 200); bus.req[0] = 1'b0;
        tick(3);

        // 4. value change after LOAD is ignored until the next grant
        set_value(0, 100);
        bus.req[0] = 1'b1;
        c = cyc;
        expect_done(0, 20'h00100, c + LAT);
        expect_done(0, 20'h00200, c + 2*LAT);
        tick(10);
        set_value(0, 200);
        wait_done(0, 200);
        wait_done(0, 200);
        bus.req[0] = 1'b0;
        tick(3);

        // 5. reset mid-WAIT aborts with no pulse
        set_value(1, 4321);
        bus.req[1] = 1'b1;
        tick(30);
        reset = 1'b1;
        tick(1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_bcd_hi", 32'(bus.bcd[59:32]), 32'd0);
        chk("midrst_bcd_lo", bus.bcd[31:0], 32'd0);
        bus.req = '0;
        reset = 1'b0;
        for (int j = 0; j < NREQ; j++) model[j] = '0;
        tick(100);
        set_value(2, 8);
        bus.req[2] = 1'b1;
        expect_done(2, 20'h00008, cyc + LAT);
        wait_done(2, 200);
        bus.req[2] = 1'b0;
        tick(3);

        // 6. idle with no requests
        snap = bus.conv_in;
        chk("idle_conv_in_nonzero", 32'(snap), 32'd8);
        for (int k = 0; k < 200; k++) begin
            tick(1);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_conv_in", 32'(bus.conv_in), 32'(snap));
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_share_sched
`default_nettype wire
